// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared FSM state, default framing constants and counter sizing helper
package bpsk_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;
  localparam int DEF_SAMPLES_PER_SYMBOL = 16;
  localparam int DEF_PREAMBLE_LEN = 8;
  localparam logic [31:0] DEF_PREAMBLE_PATTERN = 32'hAAAAAAAA;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/bpsk_symbol_timer.sv
// bpsk_symbol_timer: counts sample ticks (clken && sine_rdy) and flags the last tick of each symbol
// Ports: clk, rst (async active-low), clken, sine_rdy, clear (hold count at 0), sym_boundary (comb)
module bpsk_symbol_timer
  import bpsk_pkg::*;
#(
  parameter int SPS = DEF_SAMPLES_PER_SYMBOL
) (
  input  logic clk,
  input  logic rst,
  input  logic clken,
  input  logic sine_rdy,
  input  logic clear,
  output logic sym_boundary
);
  localparam int CW = clog2(SPS);
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = clken && sine_rdy;
  assign sym_boundary = tick && cnt == CW'(SPS - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick) cnt <= sym_boundary ? '0 : cnt + 1'b1;
endmodule

// File: rtl/bpsk_symbol_framer.sv
// bpsk_symbol_framer: prepends a preamble to handshaked payload bytes and serialises them MSB-first for the BPSK mixer
// Ports: clk, rst (async active-low); clken/sine_rdy sample timing from SINE;
//   byte_in/byte_valid/byte_last/byte_ready payload handshake; data/mod_ena to mixer;
//   busy, frame_done and underrun status. Define BPSK_DIFF_EN for differential encoding.
module bpsk_symbol_framer
  import bpsk_pkg::*;
#(
  parameter int SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter logic [31:0] PREAMBLE_PATTERN = DEF_PREAMBLE_PATTERN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       sine_rdy,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       data,
  output logic       mod_ena,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);
  state_t state;
  logic [7:0] hold;
  logic [6:0] shift;
  logic [4:0] bit_idx;
  logic hold_last, hold_full, shift_last, sym_boundary, accept, raw, nxt;
  assign byte_ready = ~hold_full;
  assign accept = byte_valid && byte_ready;
  bpsk_symbol_timer #(.SPS(SAMPLES_PER_SYMBOL)) u_timer (
    .clk(clk),
    .rst(rst),
    .clken(clken),
    .sine_rdy(sine_rdy),
    .clear(state == IDLE),
    .sym_boundary(sym_boundary)
  );
  // raw bit that becomes current at the next transition; bit_idx==0 means the next bit is a fresh byte's MSB
  always_comb
    raw = state == IDLE ? PREAMBLE_PATTERN[PREAMBLE_LEN-1]
        : bit_idx == '0 ? hold[7]
        : state == PREAMBLE ? PREAMBLE_PATTERN[bit_idx - 5'd1]
        : shift[6];
`ifdef BPSK_DIFF_EN
  // data doubles as the encoder history; it is 0 whenever idle, so frames start from a cleared state
  assign nxt = data ^ raw;
`else
  assign nxt = raw;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      hold <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      shift <= '0;
      shift_last <= 1'b0;
      bit_idx <= '0;
      data <= 1'b0;
      mod_ena <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun <= 1'b0;
      if (accept) begin
        hold <= byte_in;
        hold_last <= byte_last;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: if (hold_full && sine_rdy) begin
          state <= PREAMBLE;
          mod_ena <= 1'b1;
          busy <= 1'b1;
          bit_idx <= 5'(PREAMBLE_LEN - 1);
          data <= nxt;
        end
        PREAMBLE: if (sym_boundary) begin
          data <= nxt;
          if (bit_idx == '0) begin
            state <= PAYLOAD;
            shift <= hold[6:0];
            shift_last <= hold_last;
            hold_full <= 1'b0;
            bit_idx <= 5'd7;
          end else bit_idx <= bit_idx - 5'd1;
        end
        PAYLOAD: if (sym_boundary) begin
          if (bit_idx != '0) begin
            data <= nxt;
            shift <= {shift[5:0], 1'b0};
            bit_idx <= bit_idx - 5'd1;
          end else if (!shift_last && hold_full) begin
            data <= nxt;
            shift <= hold[6:0];
            shift_last <= hold_last;
            hold_full <= 1'b0;
            bit_idx <= 5'd7;
          end else begin
            state <= IDLE;
            mod_ena <= 1'b0;
            busy <= 1'b0;
            data <= 1'b0;
            frame_done <= shift_last;
            underrun <= !shift_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
